// File: rtl/min_unvisited_scanner.sv
// Finds the unvisited node with the smallest finite distance and marks it visited,
// or clears every visited flag. Both memories are external with one-cycle read latency.
module min_unvisited_scanner #(
  parameter int ADDR_WIDTH = 5,
  parameter int DIST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_scan,
  input  logic                  start_clear,
  output logic [ADDR_WIDTH-1:0] vis_addr,
  output logic                  vis_we,
  output logic                  vis_wdata,
  input  logic                  vis_q,
  output logic [ADDR_WIDTH-1:0] dist_addr,
  input  logic [DIST_WIDTH-1:0] dist_q,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] min_node,
  output logic [DIST_WIDTH-1:0] min_dist
);

  localparam logic [DIST_WIDTH-1:0] INF  = {DIST_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, MARK, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  eval_vld;
  logic [ADDR_WIDTH-1:0] eval_idx;
  logic                  best_vld;
  logic [ADDR_WIDTH-1:0] best_idx;
  logic [DIST_WIDTH-1:0] best_dist;
  logic                  cand;
  logic                  better;
  logic                  last;

  assign last   = (cnt == LAST);
  // read data returned this cycle belongs to the address issued last cycle
  assign cand   = eval_vld && !vis_q && (dist_q != INF);
  assign better = cand && (!best_vld || (dist_q < best_dist));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_clear)     state_nxt = CLEAR;
        else if (start_scan) state_nxt = SCAN;
      end
      CLEAR:   if (last) state_nxt = FIN;
      SCAN:    if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = (best_vld || better) ? MARK : FIN;
      MARK:    state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vis_addr  = '0;
    vis_we    = 1'b0;
    vis_wdata = 1'b0;
    dist_addr = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      CLEAR: begin
        vis_we   = 1'b1;
        vis_addr = cnt;
      end
      SCAN: begin
        vis_addr  = cnt;
        dist_addr = cnt;
      end
      MARK: begin
        vis_we    = 1'b1;
        vis_wdata = 1'b1;
        vis_addr  = best_idx;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      eval_vld  <= 1'b0;
      eval_idx  <= '0;
      best_vld  <= 1'b0;
      best_idx  <= '0;
      best_dist <= INF;
      found     <= 1'b0;
      min_node  <= '0;
      min_dist  <= INF;
    end else begin
      eval_vld <= (state == SCAN);
      eval_idx <= cnt;

      if (state == IDLE)
        cnt <= '0;
      else if ((state == CLEAR || state == SCAN) && !last)
        cnt <= cnt + ADDR_WIDTH'(1);

      // strict compare keeps the lowest index on ties
      if (state == IDLE) begin
        best_vld  <= 1'b0;
        best_idx  <= '0;
        best_dist <= INF;
      end else if (better) begin
        best_vld  <= 1'b1;
        best_idx  <= eval_idx;
        best_dist <= dist_q;
      end

      // results land on FIN entry so they are valid alongside done
      if (state_nxt == FIN) begin
        if (state == MARK) begin
          found    <= 1'b1;
          min_node <= best_idx;
          min_dist <= best_dist;
        end else begin
          found    <= 1'b0;
          min_node <= '0;
          min_dist <= INF;
        end
      end
    end
  end

endmodule

// File: tb/tb_min_unvisited_scanner.sv
// Directed bench for min_unvisited_scanner with behavioural visited/distance memories.
module tb_min_unvisited_scanner;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int N  = 32;
  localparam logic [DW-1:0] INF = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_scan = 1'b0;
  logic          start_clear = 1'b0;
  logic [AW-1:0] vis_addr;
  logic          vis_we;
  logic          vis_wdata;
  logic          vis_q;
  logic [AW-1:0] dist_addr;
  logic [DW-1:0] dist_q;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] min_node;
  logic [DW-1:0] min_dist;

  always #5 clk = ~clk;

  min_unvisited_scanner #(.ADDR_WIDTH(AW), .DIST_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_scan(start_scan), .start_clear(start_clear),
    .vis_addr(vis_addr), .vis_we(vis_we), .vis_wdata(vis_wdata), .vis_q(vis_q),
    .dist_addr(dist_addr), .dist_q(dist_q), .busy(busy), .done(done), .found(found),
    .min_node(min_node), .min_dist(min_dist)
  );

  logic          vis_mem  [N];
  logic          vis_init [N];
  logic [DW-1:0] dist_mem [N];
  logic          load = 1'b0;

  int n_done = 0;
  int wr_cnt = 0;
  int wr_ones = 0;
  int order_err = 0;
  logic [AW-1:0] clr_exp = '0;
  logic [AW-1:0] last_wa = '0;
  logic          last_wd = 1'b0;

  always @(posedge clk) begin
    vis_q  <= vis_mem[vis_addr];
    dist_q <= dist_mem[dist_addr];
    if (load) begin
      for (int i = 0; i < N; i++) vis_mem[i] <= vis_init[i];
    end else if (vis_we) begin
      vis_mem[vis_addr] <= vis_wdata;
    end
    if (done) n_done <= n_done + 1;
    if (vis_we) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= vis_addr;
      last_wd <= vis_wdata;
      if (vis_wdata) wr_ones <= wr_ones + 1;
      else begin
        if (vis_addr != clr_exp) order_err <= order_err + 1;
        clr_exp <= clr_exp + 5'd1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic load_vis(input logic v);
    for (int i = 0; i < N; i++) vis_init[i] = v;
  endtask

  task automatic push_vis;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic set_dist(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) dist_mem[i] = v;
  endtask

  logic          r_found;
  logic [AW-1:0] r_node;
  logic [DW-1:0] r_dist;

  // latency counts cycles after the edge that samples the start request
  task automatic run_op(input logic cl, input logic sc, output int lat);
    @(negedge clk); start_clear = cl; start_scan = sc;
    @(posedge clk); #1; start_clear = 1'b0; start_scan = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r_found = found;
    r_node  = min_node;
    r_dist  = min_dist;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  int lat, b_wr, b_one, b_done;

  initial begin
    load_vis(1'b1);
    set_dist(INF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_we", vis_we, 0);
    chk("rst_vaddr", vis_addr, 0);
    chk("rst_daddr", dist_addr, 0);
    chk("rst_node", min_node, 0);
    chk("rst_dist", min_dist, INF);
    @(negedge clk); rst_n = 1'b1;
    push_vis();

    b_wr = wr_cnt; b_one = wr_ones;
    run_op(1'b1, 1'b0, lat);
    chk("clr_lat", lat, 33);
    chk("clr_found", r_found, 0);
    chk("clr_writes", wr_cnt - b_wr, 32);
    chk("clr_ones", wr_ones - b_one, 0);
    chk("clr_order", order_err, 0);
    for (int i = 0; i < N; i++) chk("clr_mem", vis_mem[i], 0);

    b_wr = wr_cnt;
    run_op(1'b0, 1'b1, lat);
    chk("inf_lat", lat, 34);
    chk("inf_found", r_found, 0);
    chk("inf_dist", r_dist, INF);
    chk("inf_node", r_node, 0);
    chk("inf_writes", wr_cnt - b_wr, 0);

    for (int i = 0; i < N; i++) dist_mem[i] = 16'(100 + i);
    dist_mem[7] = 16'd5;
    b_wr = wr_cnt; b_one = wr_ones;
    run_op(1'b0, 1'b1, lat);
    chk("one_lat", lat, 35);
    chk("one_found", r_found, 1);
    chk("one_node", r_node, 7);
    chk("one_dist", r_dist, 5);
    chk("one_writes", wr_cnt - b_wr, 1);
    chk("one_ones", wr_ones - b_one, 1);
    chk("one_waddr", last_wa, 7);
    chk("one_mem7", vis_mem[7], 1);

    load_vis(1'b0);
    vis_init[1] = 1'b1;
    push_vis();
    set_dist(INF);
    dist_mem[3] = 16'd10; dist_mem[9] = 16'd10; dist_mem[1] = 16'd2;
    run_op(1'b0, 1'b1, lat);
    chk("tie1_node", r_node, 3);
    chk("tie1_dist", r_dist, 10);
    run_op(1'b0, 1'b1, lat);
    chk("tie2_node", r_node, 9);
    chk("tie2_dist", r_dist, 10);
    run_op(1'b0, 1'b1, lat);
    chk("tie3_found", r_found, 0);
    chk("tie3_lat", lat, 34);

    load_vis(1'b0);
    push_vis();
    set_dist(INF);
    dist_mem[31] = 16'd0;
    run_op(1'b0, 1'b1, lat);
    chk("last_lat", lat, 35);
    chk("last_found", r_found, 1);
    chk("last_node", r_node, 31);
    chk("last_dist", r_dist, 0);
    chk("last_mark", last_wa, 31);

    load_vis(1'b1);
    push_vis();
    b_wr = wr_cnt; b_one = wr_ones;
    run_op(1'b1, 1'b1, lat);
    chk("both_lat", lat, 33);
    chk("both_found", r_found, 0);
    chk("both_writes", wr_cnt - b_wr, 32);
    chk("both_ones", wr_ones - b_one, 0);

    for (int i = 0; i < N; i++) dist_mem[i] = 16'(100 + i);
    dist_mem[7] = 16'd5;
    b_wr = wr_cnt; b_done = n_done;
    @(negedge clk); start_scan = 1'b1;
    @(negedge clk); start_scan = 1'b0;
    repeat (4) @(negedge clk);
    start_scan = 1'b1; start_clear = 1'b1;
    @(negedge clk); start_scan = 1'b0; start_clear = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("busy_dones", n_done - b_done, 1);
    chk("busy_writes", wr_cnt - b_wr, 1);
    chk("busy_node", min_node, 7);

    load_vis(1'b0);
    push_vis();
    b_wr = wr_cnt; b_done = n_done;
    @(negedge clk); start_scan = 1'b1;
    @(posedge clk); #1; start_scan = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_we", vis_we, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - b_done, 0);
    chk("abort_no_wr", wr_cnt - b_wr, 0);
    run_op(1'b0, 1'b1, lat);
    chk("rescan_lat", lat, 35);
    chk("rescan_node", r_node, 7);
    chk("rescan_found", r_found, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/min_unvisited_scanner.md
MIN_UNVISITED_SCANNER -- requirements
Module: min_unvisited_scanner

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning node index width; node count N = 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter DIST_WIDTH, default 16, meaning distance width; the all-ones value is INF (unreachable).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start_scan  input  1  request: find the minimum-distance unvisited node and mark it visited.
REQ-006 start_clear  input  1  request: write 0 to every visited flag.
REQ-007 vis_addr  output  ADDR_WIDTH  address to the visited memory port.
REQ-008 vis_we  output  1  write enable to the visited memory port.
REQ-009 vis_wdata  output  1  write data to the visited memory port.
REQ-010 vis_q  input  1  visited memory read data, valid one cycle after vis_addr.
REQ-011 dist_addr  output  ADDR_WIDTH  distance memory read address.
REQ-012 dist_q  input  DIST_WIDTH  distance memory read data, valid one cycle after dist_addr.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 found  output  1  valid with done; 1 when a node was selected.
REQ-016 min_node  output  ADDR_WIDTH  selected node index; held until the next operation completes.
REQ-017 min_dist  output  DIST_WIDTH  selected node distance; held until the next operation completes.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, SCAN, DRAIN, MARK and FIN.
REQ-019 In IDLE, start_clear SHALL move to CLEAR; start_scan alone SHALL move to SCAN; if both are high, start_clear SHALL take priority and start_scan SHALL be dropped.
REQ-020 Starts SHALL be ignored outside IDLE; busy SHALL be 1 in every state except IDLE.
REQ-021 CLEAR SHALL last exactly N cycles, driving vis_we=1, vis_wdata=0 and vis_addr=0..N-1 in order, then go to FIN with found=0.
REQ-022 SCAN SHALL last exactly N cycles, driving vis_addr=dist_addr=i in the i-th cycle (i=0..N-1) with vis_we=0; then DRAIN for 1 cycle.
REQ-023 Each returned pair (vis_q, dist_q) SHALL be evaluated one cycle after its address, with the last pair evaluated in DRAIN.
REQ-024 A node SHALL be a candidate iff vis_q=0 and dist_q is not INF.
REQ-025 The best candidate SHALL be replaced only on strictly smaller dist_q, so ties resolve to the lowest index.
REQ-026 The best candidate SHALL be reset to none at SCAN entry.
REQ-027 After DRAIN: if a candidate exists, the FSM SHALL go to MARK; otherwise it SHALL go to FIN with found=0.
REQ-028 MARK SHALL last 1 cycle with vis_we=1, vis_wdata=1 and vis_addr=best index, then go to FIN with found=1.
REQ-029 In FIN, done SHALL be 1 for exactly one cycle, min_node/min_dist/found SHALL update, and the FSM SHALL return to IDLE.
REQ-030 Latency from the start-sampling edge to the done cycle SHALL be: scan found N+3 cycles; scan not found N+2; clear N+1.
REQ-031 On a not-found completion, min_dist SHALL be INF and min_node SHALL be 0.
REQ-032 vis_we SHALL be 0 in every state except CLEAR and MARK.
REQ-033 The address counter SHALL stop at N-1 without wrapping.

Reset
REQ-034 When rst_n=0 at an edge, the FSM SHALL enter IDLE and outputs SHALL become: busy=0, done=0, found=0, vis_we=0, vis_wdata=0, vis_addr=0, dist_addr=0, min_node=0, min_dist=INF.
REQ-035 Reset mid-operation SHALL abort with no further writes and no done pulse; a partially completed clear SHALL not be resumed.

Verification
REQ-036 Clear then scan: N=32, start_clear -> 32 writes of 0 to addr 0..31 and done at cycle 33; then all dist INF with start_scan -> done at cycle 34, found=0, min_dist=INF, no write.
REQ-037 Single minimum: dist[i]=100+i except dist[7]=5, all unvisited, start_scan -> done at cycle 35, found=1, min_node=7, min_dist=5, and exactly one write of 1 to addr 7.
REQ-038 Tie and visited skip: dist[3]=dist[9]=10, dist[1]=2 with visited[1]=1 -> min_node=3, min_dist=10; a second scan -> min_node=9.
REQ-039 Boundary index: only node 31 reachable (dist=0) -> min_node=31, evaluated in DRAIN, found=1.
REQ-040 Start handling: start_clear and start_scan together -> only the clear runs; start_scan pulsed while busy -> ignored, exactly one done.
REQ-041 Reset mid-scan: rst_n low at scan cycle 10 -> next cycle busy=0, vis_we=0, no done; a fresh start_scan then completes normally.
